la_capture_fsm: RTL and testbench



---
 rtl/la_capture_fsm.sv | 169 ++++++++++++++++
 tb/tb_la_capture_fsm.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/la_capture_fsm.sv
// Logic-analyzer capture controller: sequences sample-memory acquire/pop around a trigger and
// exposes state/config on the 16-bit register bus. Optional LA_CAPTURE_FSM_TRIG_WAIT_EN adds +4.
module la_capture_fsm #(
   parameter int unsigned  BASE_ADDR           = 0,
   parameter int unsigned  SAMPLE_DEPTH        = 4096,
   parameter int unsigned  TRIGGER_LOC_DEFAULT = 0,
   localparam int unsigned AW                  = $clog2(SAMPLE_DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          trig,
   input  logic [AW:0]   size,
   output logic          acquire,
   output logic          pop,
   output logic          done,
   input  logic [15:0]   addr_i,
   input  logic [15:0]   wdata_i,
   input  logic [15:0]   rdata_i,
   input  logic          rw_i,
   input  logic          valid_i,
   output logic [15:0]   addr_o,
   output logic [15:0]   wdata_o,
   output logic [15:0]   rdata_o,
   output logic          rw_o,
   output logic          valid_o
);

   typedef enum logic [2:0] {
      StIdle           = 3'd0,
      StDrain          = 3'd1,
      StMoveToPosition = 3'd2,
      StInPosition     = 3'd3,
      StCapturing      = 3'd4,
      StCaptured       = 3'd5
   } state_e;

   localparam logic [AW:0]   DepthFull = (AW + 1)'(SAMPLE_DEPTH);
   localparam logic [AW-1:0] LocMax    = AW'(SAMPLE_DEPTH - 1);
   localparam logic [AW-1:0] LocReset  = (TRIGGER_LOC_DEFAULT > SAMPLE_DEPTH - 1) ? LocMax :
                                         AW'(TRIGGER_LOC_DEFAULT);

   state_e        state_q, state_d;
   logic [AW-1:0] trig_loc_q, trig_loc_d;
   logic [15:0]   addr_q, wdata_q, rdata_q;
   logic          rw_q, valid_q;

   logic [15:0]   off;
   logic          wr_en, rd_en, hit, cfg_ok;
   logic          req_wr, loc_wr;
   logic [15:0]   reg_rdata;

`ifdef LA_CAPTURE_FSM_TRIG_WAIT_EN
   logic [15:0]   trig_wait_q, trig_wait_d;
`endif

   assign off    = addr_i - 16'(BASE_ADDR);
   assign wr_en  = valid_i & rw_i;
   assign rd_en  = valid_i & ~rw_i;
   assign req_wr = wr_en && (off == 16'd1);
   assign loc_wr = wr_en && (off == 16'd2);
   assign cfg_ok = (state_q == StIdle) || (state_q == StCaptured);

   // Request has no storage of its own: it reads back as "not idle".
   always_comb begin
      hit       = 1'b1;
      reg_rdata = '0;
      case (off)
         16'd0:   reg_rdata = 16'(state_q);
         16'd1:   reg_rdata = {15'd0, state_q != StIdle};
         16'd2:   reg_rdata = 16'(trig_loc_q);
         16'd3:   reg_rdata = 16'(size);
`ifdef LA_CAPTURE_FSM_TRIG_WAIT_EN
         16'd4:   reg_rdata = trig_wait_q;
`endif
         default: hit = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      acquire = 1'b0;
      pop     = 1'b0;
      done    = 1'b0;
      case (state_q)
         StIdle: ;
         StDrain: begin
            if (size != '0) pop = 1'b1;
            else            state_d = StMoveToPosition;
         end
         StMoveToPosition: begin
            if (size < {1'b0, trig_loc_q}) acquire = 1'b1;
            else                           state_d = StInPosition;
         end
         StInPosition: begin
            // Sliding window; the trigger cycle keeps its sample by skipping the pop.
            acquire = 1'b1;
            if (trig) state_d = StCapturing;
            else      pop     = 1'b1;
         end
         StCapturing: begin
            if (size < DepthFull) acquire = 1'b1;
            else                  state_d = StCaptured;
         end
         StCaptured: done = 1'b1;
         default:    state_d = StIdle;
      endcase
      // Bus request writes override any natural transition in the same cycle.
      if (req_wr) begin
         if (!wdata_i[0])  state_d = StIdle;
         else if (cfg_ok)  state_d = StDrain;
      end
   end

   always_comb begin
      trig_loc_d = trig_loc_q;
      if (loc_wr && cfg_ok) begin
         trig_loc_d = (wdata_i > 16'(SAMPLE_DEPTH - 1)) ? LocMax : wdata_i[AW-1:0];
      end
   end

`ifdef LA_CAPTURE_FSM_TRIG_WAIT_EN
   always_comb begin
      trig_wait_d = trig_wait_q;
      if (state_d == StDrain && state_q != StDrain) begin
         trig_wait_d = '0;
      end else if (state_q == StInPosition && trig_wait_q != 16'hFFFF) begin
         trig_wait_d = trig_wait_q + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) trig_wait_q <= '0;
      else        trig_wait_q <= trig_wait_d;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         trig_loc_q <= LocReset;
      end else begin
         state_q    <= state_d;
         trig_loc_q <= trig_loc_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         rw_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         addr_q  <= addr_i;
         wdata_q <= wdata_i;
         rdata_q <= (rd_en && hit) ? reg_rdata : rdata_i;
         rw_q    <= rw_i;
         valid_q <= valid_i;
      end
   end

   assign addr_o  = addr_q;
   assign wdata_o = wdata_q;
   assign rdata_o = rdata_q;
   assign rw_o    = rw_q;
   assign valid_o = valid_q;

endmodule

// File: tb/tb_la_capture_fsm.sv
// Directed bench for la_capture_fsm with a behavioural sample-memory occupancy model.
module tb_la_capture_fsm;

   localparam int unsigned Depth = 16;
   localparam logic [15:0] Base  = 16'h0040;
   localparam logic [15:0] AState = Base, AReq = Base + 16'd1, ALoc = Base + 16'd2;
   localparam logic [15:0] ASize  = Base + 16'd3, AWait = Base + 16'd4;

   logic        clk = 1'b0, rst_n = 1'b0, trig = 1'b0;
   logic [4:0]  mem_size = '0;
   logic        preload_en = 1'b0;
   logic [4:0]  preload_val = '0;
   logic        acquire, pop, done;
   logic [15:0] addr_i = '0, wdata_i = '0, rdata_i = 16'hC0DE;
   logic        rw_i = 1'b0, valid_i = 1'b0;
   logic [15:0] addr_o, wdata_o, rdata_o;
   logic        rw_o, valid_o;
   int          n_vec = 0, n_err = 0;

   la_capture_fsm #(
      .BASE_ADDR(32'(Base)),
      .SAMPLE_DEPTH(Depth),
      .TRIGGER_LOC_DEFAULT(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .trig(trig), .size(mem_size),
      .acquire(acquire), .pop(pop), .done(done),
      .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i), .rw_i(rw_i), .valid_i(valid_i),
      .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o), .rw_o(rw_o), .valid_o(valid_o)
   );

   always #5 clk = ~clk;

   // Sample memory occupancy: write pointer minus read pointer.
   always @(posedge clk) begin
      if (preload_en) mem_size <= preload_val;
      else            mem_size <= mem_size + {4'd0, acquire} - {4'd0, pop};
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
      addr_i = a; wdata_i = d; rw_i = 1'b1; valid_i = 1'b1;
      tick();
      valid_i = 1'b0; rw_i = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
      addr_i = a; rw_i = 1'b0; valid_i = 1'b1;
      tick();
      d = rdata_o;
      valid_i = 1'b0;
   endtask

   task automatic preload(input logic [4:0] v);
      preload_val = v; preload_en = 1'b1;
      tick();
      preload_en = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] d;
      tick(); tick();
      n_vec++; if ({acquire, pop, done} !== 3'b000) begin
         n_err++; $display("FAIL reset_outs got=%b exp=000", {acquire, pop, done}); end
      n_vec++; if ({valid_o, rw_o, addr_o, wdata_o, rdata_o} !== 50'd0) begin
         n_err++; $display("FAIL reset_bus got valid=%b addr=%h rdata=%h exp=0", valid_o, addr_o,
                           rdata_o); end
      rst_n = 1'b1;
      tick();
      bus_read(AState, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", d); end
      n_vec++; if (valid_o !== 1'b1 || addr_o !== AState) begin
         n_err++; $display("FAIL read_latency valid=%b addr=%h exp 1/%h", valid_o, addr_o, AState);
      end
      bus_read(ALoc, d);
      n_vec++; if (d !== 16'd3) begin n_err++; $display("FAIL reset_tloc got=%0d exp=3", d); end
      bus_read(AReq, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL reset_req got=%0d exp=0", d); end
   endtask

   task automatic test_capture();
      logic [15:0] d;
      logic        ea, ep;
      int          acq_n, pop_n;
      preload(5'd0);
      bus_write(ALoc, 16'd4);
      bus_write(AReq, 16'd1);
      // 0: drain(empty), 1-4: pre-fill, 5: settle, 6-7: sliding window
      for (int c = 0; c < 8; c++) begin
         ea = (c >= 1 && c <= 4) || c >= 6;
         ep = c >= 6;
         n_vec++; if ({acquire, pop} !== {ea, ep}) begin
            n_err++; $display("FAIL capture_seq c=%0d acq,pop got=%b%b exp=%b%b", c, acquire, pop,
                              ea, ep); end
         tick();
      end
      n_vec++; if (mem_size !== 5'd4 || {acquire, pop} !== 2'b11) begin
         n_err++; $display("FAIL window_hold size=%0d acq,pop=%b%b exp 4/11", mem_size, acquire,
                           pop); end
      trig = 1'b1;
      #1;
      n_vec++; if ({acquire, pop} !== 2'b10) begin
         n_err++; $display("FAIL trig_cycle acq,pop got=%b%b exp=10", acquire, pop); end
      acq_n = 1; pop_n = 0;
      tick();
      trig = 1'b0;
      #1;
      for (int c = 9; c <= 21; c++) begin
         acq_n += int'(acquire);
         pop_n += int'(pop);
         if (c != 21) tick();
      end
      n_vec++; if (acq_n != 12 || pop_n != 0) begin
         n_err++; $display("FAIL post_trig acquires=%0d pops=%0d exp 12/0", acq_n, pop_n); end
      n_vec++; if (done !== 1'b1 || mem_size !== 5'd16) begin
         n_err++; $display("FAIL captured done=%b size=%0d exp 1/16", done, mem_size); end
      bus_read(AState, d);
      n_vec++; if (d !== 16'd5) begin n_err++; $display("FAIL state_captured got=%0d exp=5", d); end
      bus_read(ASize, d);
      n_vec++; if (d !== 16'd16) begin n_err++; $display("FAIL size_reg got=%0d exp=16", d); end
      bus_read(AReq, d);
      n_vec++; if (d !== 16'd1) begin n_err++; $display("FAIL req_captured got=%0d exp=1", d); end
   endtask

   task automatic test_drain();
      logic [15:0] d;
      int          acq_n, pop_n;
      preload(5'd7);
      bus_write(AReq, 16'd1);
      acq_n = 0; pop_n = 0;
      for (int c = 0; c < 8; c++) begin
         acq_n += int'(acquire);
         pop_n += int'(pop);
         tick();
      end
      n_vec++; if (pop_n != 7 || acq_n != 0) begin
         n_err++; $display("FAIL drain pops=%0d acquires=%0d exp 7/0", pop_n, acq_n); end
      n_vec++; if (acquire !== 1'b1 || mem_size !== 5'd0) begin
         n_err++; $display("FAIL drain_exit acq=%b size=%0d exp 1/0", acquire, mem_size); end
      bus_read(AState, d);
      n_vec++; if (d !== 16'd2) begin n_err++; $display("FAIL state_move got=%0d exp=2", d); end
      bus_write(AReq, 16'd0);
      n_vec++; if ({acquire, pop} !== 2'b00) begin
         n_err++; $display("FAIL stop_move acq,pop got=%b%b exp=00", acquire, pop); end
   endtask

   task automatic test_trig_early();
      logic [15:0] d;
      logic        ea;
      preload(5'd0);
      bus_write(ALoc, 16'd3);
      trig = 1'b1;
      bus_write(AReq, 16'd1);
      for (int c = 0; c <= 6; c++) begin
         ea = (c >= 1 && c <= 3) || c >= 5;
         n_vec++; if ({acquire, pop} !== {ea, 1'b0}) begin
            n_err++; $display("FAIL early_trig c=%0d acq,pop got=%b%b exp=%b0", c, acquire, pop, ea);
         end
         if (c != 6) tick();
      end
      trig = 1'b0;
      bus_read(AState, d);
      n_vec++; if (d !== 16'd4) begin n_err++; $display("FAIL state_capturing got=%0d exp=4", d); end
   endtask

   task automatic test_abort();
      logic [15:0] d;
      bus_write(ALoc, 16'd2);
      bus_read(ALoc, d);
      n_vec++; if (d !== 16'd3) begin n_err++; $display("FAIL tloc_locked got=%0d exp=3", d); end
      bus_write(AReq, 16'd0);
      n_vec++; if (acquire !== 1'b0) begin
         n_err++; $display("FAIL abort_acq got=%b exp=0", acquire); end
      bus_read(AState, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL abort_state got=%0d exp=0", d); end
      bus_read(AReq, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL abort_req got=%0d exp=0", d); end
      bus_write(ALoc, 16'd20);
      bus_read(ALoc, d);
      n_vec++; if (d !== 16'd15) begin n_err++; $display("FAIL tloc_clamp got=%0d exp=15", d); end
   endtask

   task automatic test_passthrough();
      logic [15:0] d;
      rdata_i = 16'h1234;
      bus_read(Base + 16'd6, d);
      n_vec++; if (d !== 16'h1234 || addr_o !== Base + 16'd6 || rw_o !== 1'b0) begin
         n_err++; $display("FAIL pass_read rdata=%h addr=%h rw=%b exp 1234/%h/0", d, addr_o, rw_o,
                           Base + 16'd6); end
      bus_read(Base - 16'd1, d);
      n_vec++; if (d !== 16'h1234) begin n_err++; $display("FAIL pass_below got=%h exp=1234", d); end
      bus_write(16'h0100, 16'hA5A5);
      n_vec++; if ({valid_o, rw_o, addr_o, wdata_o} !== {2'b11, 16'h0100, 16'hA5A5}) begin
         n_err++; $display("FAIL pass_write v=%b rw=%b addr=%h wdata=%h exp 1/1/0100/a5a5", valid_o,
                           rw_o, addr_o, wdata_o); end
   endtask

   task automatic test_trig_wait();
      logic [15:0] d;
      preload(5'd0);
      bus_write(ALoc, 16'd0);
      bus_write(AReq, 16'd1);
      tick(); tick();
      // First in-position cycle at empty memory: paired acquire+pop is the one allowed pop at 0.
      n_vec++; if ({acquire, pop} !== 2'b11 || mem_size !== 5'd0) begin
         n_err++; $display("FAIL empty_window acq,pop=%b%b size=%0d exp 11/0", acquire, pop,
                           mem_size); end
      for (int c = 0; c < 9; c++) tick();
      trig = 1'b1;
      #1;
      n_vec++; if ({acquire, pop} !== 2'b10 || mem_size !== 5'd0) begin
         n_err++; $display("FAIL wait_trig acq,pop=%b%b size=%0d exp 10/0", acquire, pop, mem_size);
      end
      tick();
      trig = 1'b0;
      rdata_i = 16'h5A5A;
      bus_read(AWait, d);
`ifdef LA_CAPTURE_FSM_TRIG_WAIT_EN
      n_vec++; if (d !== 16'd10) begin n_err++; $display("FAIL trig_wait got=%0d exp=10", d); end
`else
      n_vec++; if (d !== 16'h5A5A) begin
         n_err++; $display("FAIL wait_undecoded got=%h exp=5a5a", d); end
`endif
      bus_write(AReq, 16'd0);
   endtask

   task automatic test_reset_mid();
      logic [15:0] d;
      preload(5'd0);
      bus_write(ALoc, 16'd2);
      bus_write(AReq, 16'd1);
      for (int c = 0; c < 4; c++) tick();
      trig = 1'b1;
      tick();
      trig = 1'b0;
      #1;
      n_vec++; if (acquire !== 1'b1) begin
         n_err++; $display("FAIL mid_capturing acq got=%b exp=1", acquire); end
      rst_n = 1'b0;
      #1;
      n_vec++; if ({acquire, pop, done, valid_o} !== 4'b0000) begin
         n_err++; $display("FAIL async_reset acq,pop,done,valid got=%b exp=0000",
                           {acquire, pop, done, valid_o}); end
      tick();
      rst_n = 1'b1;
      tick();
      bus_read(AState, d);
      n_vec++; if (d !== 16'd0) begin n_err++; $display("FAIL mid_reset_state got=%0d exp=0", d); end
      bus_read(ALoc, d);
      n_vec++; if (d !== 16'd3) begin n_err++; $display("FAIL mid_reset_tloc got=%0d exp=3", d); end
   endtask

   initial begin
      test_reset();
      test_capture();
      test_drain();
      test_trig_early();
      test_abort();
      test_passthrough();
      test_trig_wait();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
